// File: rtl/button_pkg.sv
// Shared types, defaults and helpers for the multi-channel button front end.
package button_pkg;

  // Arbiter states: IDLE looks for a pending channel, WRITE is the mandatory gap cycle.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_t;

  // Board defaults at 50 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat period.
  localparam int DEF_DEB_CYCLES   = 32'sd500000;
  localparam int DEF_REPEAT_EN    = 32'sd0;
  localparam int DEF_REPEAT_DELAY = 32'sd25000000;
  localparam int DEF_REPEAT_RATE  = 32'sd5000000;

  // Channel id width; a single channel still gets one id bit.
  function automatic int id_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser, debounce counter, press detect and
// optional auto-repeat. event_pulse is high for one cycle per press or repeat.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_EN    = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic event_pulse
);

  logic        sync1_r;
  logic        sync2_r;
  logic        deb_r;
  logic [31:0] cnt_r;
  logic [31:0] rep_cnt_r;
  logic        rep_first_r;
  logic        flip_s;
  logic        press_s;
  logic        release_s;
  logic        rep_fire_s;
  logic [31:0] rep_target_s;

  // The debounced level flips on the DEB_CYCLES-th consecutive differing cycle.
  assign flip_s       = (sync2_r != deb_r) && (cnt_r == 32'(DEB_CYCLES - 32'sd1));
  assign press_s      = flip_s && deb_r;
  assign release_s    = flip_s && !deb_r;
  assign rep_target_s = rep_first_r ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE);
  assign rep_fire_s   = (REPEAT_EN != 32'sd0) && !deb_r && !release_s &&
                        (rep_cnt_r == rep_target_s);
  assign event_pulse  = press_s || rep_fire_s;

  // Two-stage synchroniser for the asynchronous pin; idles at released (1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter: counts differing cycles, clears on any match or on a flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= 1'b1;
      cnt_r <= 32'd0;
    end else if (sync2_r == deb_r) begin
      cnt_r <= 32'd0;
    end else if (flip_s) begin
      deb_r <= sync2_r;
      cnt_r <= 32'd0;
    end else begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // Repeat counter: counts cycles since the last press/repeat while held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b1;
    end else if (REPEAT_EN == 32'sd0) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b1;
    end else if (press_s) begin
      rep_cnt_r   <= 32'd1;
      rep_first_r <= 1'b1;
    end else if (deb_r || release_s) begin
      rep_cnt_r   <= 32'd0;
      rep_first_r <= 1'b1;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= 32'd1;
      rep_first_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_r + 32'd1;
    end
  end

endmodule

// File: rtl/button_event_arb.sv
// Button front end top: per-channel debouncers, pending/snapshot registers and a
// round-robin arbiter that feeds one command-FIFO write every other cycle at most.
module button_event_arb
  import button_pkg::*;
#(
  parameter int N_BTN        = 32'sd4,
  parameter int DATA_W       = 32'sd8,
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_EN    = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  localparam int ID_W        = id_width(N_BTN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       button,
  input  logic [DATA_W-1:0]      sw,
  input  logic                   fifo_full,
  input  logic                   overrun_clr,
  output logic                   fifo_wr_en,
  output logic [ID_W+DATA_W-1:0] fifo_wr_data,
  output logic [N_BTN-1:0]       overrun
);

  arb_state_t              state_r;
  logic [N_BTN-1:0]        event_s;
  logic [N_BTN-1:0]        pending_r;
  logic [N_BTN-1:0]        overrun_r;
  logic [DATA_W-1:0]       snap_r [N_BTN];
  logic [ID_W-1:0]         last_grant_r;
  logic                    fifo_wr_en_r;
  logic [ID_W+DATA_W-1:0]  fifo_wr_data_r;
  logic                    grant_valid_s;
  logic [ID_W-1:0]         grant_id_s;
  logic                    do_grant_s;
  logic [N_BTN-1:0]        grant_s;

  for (genvar g = 32'sd0; g < N_BTN; g++) begin : g_ch
    button_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .button     (button[g]),
      .event_pulse(event_s[g])
    );
  end

  // Round-robin pick: first pending channel above last_grant, wrapping around.
  always_comb begin
    logic [ID_W-1:0] cand_v;
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    cand_v        = '0;
    for (int i = 32'sd1; i <= N_BTN; i++) begin
      cand_v = ID_W'((int'(last_grant_r) + i) % N_BTN);
      if (!grant_valid_s && pending_r[cand_v]) begin
        grant_valid_s = 1'b1;
        grant_id_s    = cand_v;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    do_grant_s = (state_r == ST_IDLE) && grant_valid_s && !fifo_full;
    if (do_grant_s) begin
      grant_s = N_BTN'(1'b1) << grant_id_s;
    end else begin
      grant_s = '0;
    end
  end

  // Pending/snapshot/overrun per channel; a grant in the same cycle frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= '0;
      overrun_r <= '0;
      for (int c = 32'sd0; c < N_BTN; c++) begin
        snap_r[c] <= '0;
      end
    end else begin
      for (int c = 32'sd0; c < N_BTN; c++) begin
        if (event_s[c] && (!pending_r[c] || grant_s[c])) begin
          pending_r[c] <= 1'b1;
          snap_r[c]    <= sw;
        end else if (grant_s[c]) begin
          pending_r[c] <= 1'b0;
        end else begin
          pending_r[c] <= pending_r[c];
        end
        if (event_s[c] && pending_r[c] && !grant_s[c]) begin
          overrun_r[c] <= 1'b1;
        end else if (overrun_clr) begin
          overrun_r[c] <= 1'b0;
        end else begin
          overrun_r[c] <= overrun_r[c];
        end
      end
    end
  end

  // Arbiter FSM with registered write strobe and data; WRITE is always one gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= '0;
      last_grant_r   <= ID_W'(N_BTN - 32'sd1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (do_grant_s) begin
            fifo_wr_en_r   <= 1'b1;
            fifo_wr_data_r <= {grant_id_s, snap_r[grant_id_s]};
            last_grant_r   <= grant_id_s;
            state_r        <= ST_WRITE;
          end else begin
            fifo_wr_en_r   <= 1'b0;
          end
        end
        ST_WRITE: begin
          fifo_wr_en_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          fifo_wr_en_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_button_event_arb.sv
// Directed bench for button_event_arb: 4 channels, 4-cycle debounce, auto-repeat
// with delay 20 / rate 8. Every FIFO write is logged with its edge number.
module tb_button_event_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button;
  logic [7:0] sw;
  logic       fifo_full;
  logic       overrun_clr;
  logic       fifo_wr_en;
  logic [9:0] fifo_wr_data;
  logic [3:0] overrun;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         t0;
  int         r0;
  int         wr_cyc_q [$];
  logic [9:0] wr_dat_q [$];

  button_event_arb #(
    .N_BTN       (4),
    .DATA_W      (8),
    .DEB_CYCLES  (4),
    .REPEAT_EN   (1),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .sw          (sw),
    .fifo_full   (fifo_full),
    .overrun_clr (overrun_clr),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k the value is k.
  always @(posedge clk) cyc <= cyc + 1;

  // Write logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_dat_q.push_back(fifo_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input int exp_cyc,
                             input logic [9:0] exp_dat);
    int         gc;
    logic [9:0] gd;
    if (idx < wr_cyc_q.size()) begin
      gc = wr_cyc_q[idx];
      gd = wr_dat_q[idx];
    end else begin
      gc = -1;
      gd = 'x;
    end
    check_val({tag, "_cyc"}, gc, exp_cyc);
    check_val({tag, "_data"}, {22'd0, gd}, {22'd0, exp_dat});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cyc_q.delete();
    wr_dat_q.delete();
  endtask

  initial begin
    button      = 4'hF;
    sw          = 8'h00;
    fifo_full   = 1'b0;
    overrun_clr = 1'b0;
    rst         = 1'b1;
    step(3);
    check_val("rst_wr_en", fifo_wr_en, 0);
    check_val("rst_wr_data", fifo_wr_data, 0);
    check_val("rst_overrun", overrun, 0);
    rst = 1'b0;
    step(3);

    // 1: single press on ch2, write after edge 7
    clear_log();
    sw = 8'hA5; button[2] = 1'b0; t0 = cyc;
    step(6); button[2] = 1'b1; step(20);
    check_val("t1_count", wr_cyc_q.size(), 1);
    check_write("t1", 0, t0 + 7, {2'd2, 8'hA5});

    // 2: bounces shorter than the debounce window, then a real 4-cycle press
    clear_log();
    sw = 8'h3C;
    button[0] = 1'b0; step(3); button[0] = 1'b1; step(2);
    button[0] = 1'b0; step(3); button[0] = 1'b1; step(15);
    check_val("t2_bounce_none", wr_cyc_q.size(), 0);
    t0 = cyc; button[0] = 1'b0; step(4); button[0] = 1'b1; step(15);
    check_val("t2_count", wr_cyc_q.size(), 1);
    check_write("t2", 0, t0 + 7, {2'd0, 8'h3C});

    // 3: prior grant to ch1, then ch1 and ch3 together -> ch3 first, gap, ch1
    clear_log();
    sw = 8'h77; t0 = cyc; button[1] = 1'b0; step(6); button[1] = 1'b1; step(15);
    check_write("t3_prior", 0, t0 + 7, {2'd1, 8'h77});
    clear_log();
    sw = 8'h5A; t0 = cyc; button[1] = 1'b0; button[3] = 1'b0;
    step(6); button[1] = 1'b1; button[3] = 1'b1; step(15);
    check_val("t3_count", wr_cyc_q.size(), 2);
    check_write("t3_first", 0, t0 + 7, {2'd3, 8'h5A});
    check_write("t3_second", 1, t0 + 9, {2'd1, 8'h5A});

    // 4: back-pressure, overrun on second press, old snapshot kept
    clear_log();
    fifo_full = 1'b1; sw = 8'h11;
    button[0] = 1'b0; step(6); button[0] = 1'b1; step(10);
    sw = 8'h22;
    button[0] = 1'b0; step(6); button[0] = 1'b1; step(20);
    check_val("t4_no_write", wr_cyc_q.size(), 0);
    check_val("t4_overrun", overrun, 4'b0001);
    fifo_full = 1'b0; t0 = cyc; step(6);
    check_val("t4_count", wr_cyc_q.size(), 1);
    check_write("t4", 0, t0 + 1, {2'd0, 8'h11});
    check_val("t4_overrun_hold", overrun, 4'b0001);
    overrun_clr = 1'b1; step(1); overrun_clr = 1'b0;
    check_val("t4_overrun_clr", overrun, 4'b0000);

    // 5: auto-repeat on ch1: press at edge t0+6, repeats at +20,+28,+36,+44
    clear_log();
    sw = 8'hC3; t0 = cyc; button[1] = 1'b0;
    step(50); button[1] = 1'b1; step(40);
    check_val("t5_count", wr_cyc_q.size(), 5);
    check_write("t5_press", 0, t0 + 7, {2'd1, 8'hC3});
    check_write("t5_rep1", 1, t0 + 27, {2'd1, 8'hC3});
    check_write("t5_rep2", 2, t0 + 35, {2'd1, 8'hC3});
    check_write("t5_rep3", 3, t0 + 43, {2'd1, 8'hC3});
    check_write("t5_rep4", 4, t0 + 51, {2'd1, 8'hC3});

    // 6: reset with ch2 pending and FSM in WRITE; ch2 held through reset
    clear_log();
    sw = 8'h9D; t0 = cyc; button[3] = 1'b0; step(1); button[2] = 1'b0; step(6);
    check_val("t6_pre_wr_en", fifo_wr_en, 1);
    check_val("t6_pre_data", fifo_wr_data, {2'd3, 8'h9D});
    #2 rst = 1'b1; button[3] = 1'b1;
    #1;
    check_val("t6_rst_wr_en", fifo_wr_en, 0);
    check_val("t6_rst_wr_data", fifo_wr_data, 0);
    check_val("t6_rst_overrun", overrun, 0);
    clear_log();
    step(2);
    rst = 1'b0; r0 = cyc;
    step(15);
    check_val("t6_count", wr_cyc_q.size(), 1);
    check_write("t6_fresh", 0, r0 + 7, {2'd2, 8'h9D});
    button[2] = 1'b1;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
